// File: rtl/me_dmt_pkg.sv
// Shared types and constants for the DMT motion-estimation result path.
// Search-window centre feeds the optional MV cost penalty (MV_COST_EN).
package me_dmt_pkg;

  localparam int NUM_CB  = 4;
  localparam int COL_CTR = 16;
  localparam int ROW_CTR = 32;

  localparam int SAD_W_D = 16;
  localparam int COL_W_D = 5;
  localparam int ROW_W_D = 7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DRAIN  = 2'd2
  } sel_state_e;

  typedef struct packed {
    logic [1:0]         cb;
    logic [SAD_W_D-1:0] cost;
    logic [COL_W_D-1:0] col;
    logic [ROW_W_D-1:0] row;
    logic               hit;
  } res_t;

endpackage

// File: rtl/sad_min_cell.sv
// Single sub-block minimum tracker: strict-less update, first-found wins ties.
// The first sample after a clear is always taken regardless of value.
module sad_min_cell
  import me_dmt_pkg::*;
#(
  parameter int SAD_W = 16,
  parameter int COL_W = 5,
  parameter int ROW_W = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             upd,
  input  logic [SAD_W-1:0] cand,
  input  logic [COL_W-1:0] col,
  input  logic [ROW_W-1:0] row,
  output logic [SAD_W-1:0] best_cost,
  output logic [COL_W-1:0] best_col,
  output logic [ROW_W-1:0] best_row,
  output logic             hit
);

  logic [SAD_W-1:0] cost_q, cost_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             hit_q, hit_d;
  logic             take;

  always_comb begin
    take   = upd && (!hit_q || (cand < cost_q));
    cost_d = cost_q;
    col_d  = col_q;
    row_d  = row_q;
    hit_d  = hit_q;
    if (clr) begin
      cost_d = '1;
      col_d  = '0;
      row_d  = '0;
      hit_d  = 1'b0;
    end else if (take) begin
      cost_d = cand;
      col_d  = col;
      row_d  = row;
      hit_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cost_q <= '1;
      col_q  <= '0;
      row_q  <= '0;
      hit_q  <= 1'b0;
    end else begin
      cost_q <= cost_d;
      col_q  <= col_d;
      row_q  <= row_d;
      hit_q  <= hit_d;
    end
  end

  assign best_cost = cost_q;
  assign best_col  = col_q;
  assign best_row  = row_q;
  assign hit       = hit_q;

endmodule

// File: rtl/sad_best_match_sel.sv
// Best-match selector: per-CB minimum SAD over one search, then 4-word drain.
// Define MV_COST_EN to add a saturating motion-vector distance penalty.
module sad_best_match_sel
  import me_dmt_pkg::*;
#(
  parameter int SAD_W        = 16,
  parameter int COL_W        = 5,
  parameter int ROW_W        = 7,
  parameter int LAMBDA_SHIFT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sad_valid,
  input  logic [1:0]       sad_cb,
  input  logic [SAD_W-1:0] sad_value,
  input  logic [COL_W-1:0] sad_col,
  input  logic [ROW_W-1:0] sad_row,
  input  logic             search_done,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [1:0]       res_cb,
  output logic [SAD_W-1:0] res_cost,
  output logic [COL_W-1:0] res_col,
  output logic [ROW_W-1:0] res_row,
  output logic             res_hit,
  output logic             busy,
  output logic             blk_done
);

  sel_state_e       state_q, state_d;
  logic [1:0]       k_q, k_d;
  logic             done_q, done_d;
  logic [SAD_W-1:0] cand;
  logic             clr;

  logic [SAD_W-1:0] cost_a [NUM_CB];
  logic [COL_W-1:0] col_a  [NUM_CB];
  logic [ROW_W-1:0] row_a  [NUM_CB];
  logic             hit_a  [NUM_CB];

`ifdef MV_COST_EN
  logic [COL_W-1:0] dcol;
  logic [ROW_W-1:0] drow;
  logic [31:0]      pen;
  logic [31:0]      sum;

  always_comb begin
    dcol = (sad_col >= COL_W'(COL_CTR)) ? sad_col - COL_W'(COL_CTR)
                                         : COL_W'(COL_CTR) - sad_col;
    drow = (sad_row >= ROW_W'(ROW_CTR)) ? sad_row - ROW_W'(ROW_CTR)
                                         : ROW_W'(ROW_CTR) - sad_row;
    pen  = (32'(dcol) + 32'(drow)) << LAMBDA_SHIFT;
    sum  = 32'(sad_value) + pen;
    cand = (sum > 32'({SAD_W{1'b1}})) ? '1 : sum[SAD_W-1:0];
  end
`else
  localparam int unused_lambda = LAMBDA_SHIFT;
  assign cand = sad_value;
`endif

  // Start clears trackers in IDLE and SEARCH; a same-cycle sample is dropped.
  assign clr = start && (state_q != DRAIN);

  for (genvar i = 0; i < NUM_CB; i++) begin : g_cell
    sad_min_cell #(
      .SAD_W (SAD_W),
      .COL_W (COL_W),
      .ROW_W (ROW_W)
    ) u_cell (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (clr),
      .upd       ((state_q == SEARCH) && sad_valid && !start
                  && (sad_cb == 2'(i))),
      .cand      (cand),
      .col       (sad_col),
      .row       (sad_row),
      .best_cost (cost_a[i]),
      .best_col  (col_a[i]),
      .best_row  (row_a[i]),
      .hit       (hit_a[i])
    );
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = SEARCH;
      end
      SEARCH: begin
        if (!start && search_done) begin
          state_d = DRAIN;
          k_d     = 2'd0;
        end
      end
      DRAIN: begin
        if (res_ready) begin
          if (k_q == 2'd3) begin
            state_d = IDLE;
            k_d     = 2'd0;
            done_d  = 1'b1;
          end else begin
            k_d = k_q + 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= 2'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      done_q  <= done_d;
    end
  end

  // Trackers are frozen during DRAIN, so the k-indexed view is stable.
  assign res_valid = (state_q == DRAIN);
  assign res_cb    = res_valid ? k_q : 2'd0;
  assign res_cost  = res_valid ? cost_a[k_q] : '0;
  assign res_col   = res_valid ? col_a[k_q] : '0;
  assign res_row   = res_valid ? row_a[k_q] : '0;
  assign res_hit   = res_valid && hit_a[k_q];
  assign busy      = (state_q != IDLE);
  assign blk_done  = done_q;

endmodule

// File: tb/tb_sad_best_match_sel.sv
// Directed bench for sad_best_match_sel; expectations track MV_COST_EN.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_sad_best_match_sel;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        sad_valid;
  logic [1:0]  sad_cb;
  logic [15:0] sad_value;
  logic [4:0]  sad_col;
  logic [6:0]  sad_row;
  logic        search_done;
  logic        res_valid;
  logic        res_ready;
  logic [1:0]  res_cb;
  logic [15:0] res_cost;
  logic [4:0]  res_col;
  logic [6:0]  res_row;
  logic        res_hit;
  logic        busy;
  logic        blk_done;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sad_best_match_sel dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .sad_valid   (sad_valid),
    .sad_cb      (sad_cb),
    .sad_value   (sad_value),
    .sad_col     (sad_col),
    .sad_row     (sad_row),
    .search_done (search_done),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_cb      (res_cb),
    .res_cost    (res_cost),
    .res_col     (res_col),
    .res_row     (res_row),
    .res_hit     (res_hit),
    .busy        (busy),
    .blk_done    (blk_done)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] cb, input logic [15:0] v,
                      input logic [4:0] c, input logic [6:0] r,
                      input logic done);
    sad_valid   = 1'b1;
    sad_cb      = cb;
    sad_value   = v;
    sad_col     = c;
    sad_row     = r;
    search_done = done;
    cyc();
    sad_valid   = 1'b0;
    search_done = 1'b0;
  endtask

  task automatic chk_res(input string tag, input logic [1:0] cb,
                         input logic [15:0] cost, input logic [4:0] c,
                         input logic [6:0] r, input logic hit);
    chk({tag, ".valid"}, 32'(res_valid), 32'd1);
    chk({tag, ".cb"},    32'(res_cb),    32'(cb));
    chk({tag, ".cost"},  32'(res_cost),  32'(cost));
    chk({tag, ".col"},   32'(res_col),   32'(c));
    chk({tag, ".row"},   32'(res_row),   32'(r));
    chk({tag, ".hit"},   32'(res_hit),   32'(hit));
  endtask

`ifdef MV_COST_EN
  localparam logic [15:0] A_C0 = 16'd284;
  localparam logic [4:0]  A_C0COL = 5'd6;
  localparam logic [6:0]  A_C0ROW = 7'd21;
  localparam logic [15:0] A_C1 = 16'd234;
  localparam logic [15:0] A_C2 = 16'd284;
  localparam logic [15:0] M_C0 = 16'd98;
  localparam logic [15:0] M_C1 = 16'hFFFF;
`else
  localparam logic [15:0] A_C0 = 16'd200;
  localparam logic [4:0]  A_C0COL = 5'd5;
  localparam logic [6:0]  A_C0ROW = 7'd20;
  localparam logic [15:0] A_C1 = 16'd50;
  localparam logic [15:0] A_C2 = 16'd100;
  localparam logic [15:0] M_C0 = 16'd90;
  localparam logic [15:0] M_C1 = 16'hFFF0;
`endif

  initial begin
    rst_n       = 1'b0;
    start       = 1'b0;
    sad_valid   = 1'b0;
    sad_cb      = 2'd0;
    sad_value   = 16'd0;
    sad_col     = 5'd0;
    sad_row     = 7'd0;
    search_done = 1'b0;
    res_ready   = 1'b0;
    cyc();
    chk("rst.valid", 32'(res_valid), 32'd0);
    chk("rst.busy",  32'(busy),      32'd0);
    chk("rst.done",  32'(blk_done),  32'd0);
    chk("rst.cost",  32'(res_cost),  32'd0);
    rst_n = 1'b1;
    cyc();

    // IDLE ignores sad_valid and search_done
    send(2'd0, 16'd1, 5'd9, 7'd9, 1'b1);
    chk("idle.busy", 32'(busy), 32'd0);

    // Main search: ties, back-to-back CB, sample with search_done
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("a.busy", 32'(busy), 32'd1);
    send(2'd0, 16'd500, 5'd3, 7'd10, 1'b0);
    send(2'd0, 16'd200, 5'd5, 7'd20, 1'b0);
    send(2'd0, 16'd200, 5'd6, 7'd21, 1'b0);
    send(2'd0, 16'd900, 5'd7, 7'd1,  1'b0);
    send(2'd2, 16'd300, 5'd0, 7'd1,  1'b0);
    send(2'd2, 16'd100, 5'd0, 7'd2,  1'b0);
    send(2'd2, 16'd150, 5'd0, 7'd3,  1'b0);
    send(2'd1, 16'd50,  5'd1, 7'd1,  1'b1);
    chk_res("a.k0", 2'd0, A_C0, A_C0COL, A_C0ROW, 1'b1);
    res_ready = 1'b1;
    cyc();
    res_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_res("a.k1stall", 2'd1, A_C1, 5'd1, 7'd1, 1'b1);
      cyc();
    end
    chk_res("a.k1", 2'd1, A_C1, 5'd1, 7'd1, 1'b1);
    res_ready = 1'b1;
    cyc();
    chk_res("a.k2", 2'd2, A_C2, 5'd0, 7'd2, 1'b1);
    cyc();
    chk_res("a.k3", 2'd3, 16'hFFFF, 5'd0, 7'd0, 1'b0);
    cyc();
    chk("a.blk_done", 32'(blk_done),  32'd1);
    chk("a.end_vld",  32'(res_valid), 32'd0);
    chk("a.end_busy", 32'(busy),      32'd0);
    cyc();
    chk("a.blk_once", 32'(blk_done),  32'd0);

    // Penalty path, restart in SEARCH, full-throughput drain
    res_ready = 1'b0;
    start = 1'b1;
    cyc();
    send(2'd3, 16'd5, 5'd16, 7'd32, 1'b0);
    start = 1'b1;
    send(2'd3, 16'd3, 5'd16, 7'd32, 1'b0);
    start = 1'b0;
    send(2'd0, 16'd100,   5'd16, 7'd32, 1'b0);
    send(2'd0, 16'd90,    5'd18, 7'd32, 1'b0);
    send(2'd1, 16'hFFF0,  5'd0,  7'd0,  1'b1);
    res_ready = 1'b1;
    chk_res("m.k0", 2'd0, M_C0, 5'd18, 7'd32, 1'b1);
    cyc();
    chk_res("m.k1", 2'd1, M_C1, 5'd0, 7'd0, 1'b1);
    cyc();
    chk_res("m.k2", 2'd2, 16'hFFFF, 5'd0, 7'd0, 1'b0);
    cyc();
    chk_res("m.k3", 2'd3, 16'hFFFF, 5'd0, 7'd0, 1'b0);
    cyc();
    chk("m.blk_done", 32'(blk_done), 32'd1);

    // Reset during DRAIN at k=2, then an empty search
    start = 1'b1;
    cyc();
    start = 1'b0;
    send(2'd0, 16'd7, 5'd1, 7'd1, 1'b1);
    cyc();
    cyc();
    chk("r.k2cb", 32'(res_cb), 32'd2);
    res_ready = 1'b0;
    rst_n = 1'b0;
    #2;
    chk("r.valid", 32'(res_valid), 32'd0);
    chk("r.busy",  32'(busy),      32'd0);
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("r.idle", 32'(busy), 32'd0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    search_done = 1'b1;
    cyc();
    search_done = 1'b0;
    chk_res("r.k0", 2'd0, 16'hFFFF, 5'd0, 7'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
